// File: rtl/mem_pkg.sv
// Shared data-memory types: access size encoding and responder FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for a 32-bit little-endian data port: store byte enables and
// data replication, load lane extraction with sign/zero extension, misalignment detect.
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  type_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
    return {{24{s & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
    return {{16{s & h[15]}}, h};
  endfunction

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    rdata_o    = rword_i;
    misalign_o = 1'b0;
    case (type_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = ext8(rword_i[{addr_lo_i, 3'b000} +: 8], sign_i);
      end
      MEM_HALF: begin
        // addr[0] never selects a lane; it only flags misalignment
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = ext16(rword_i[{addr_lo_i[1], 4'b0000} +: 16], sign_i);
        misalign_o = addr_lo_i[0];
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port with WAIT_CYCLES wait states per access.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses with rsp_err_o.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int unsigned            DEPTH     = 2 ** (ADDR_WIDTH - 2);
  localparam bit                     NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  dmem_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  wr_q, wr_d;
  logic                  sign_q, sign_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  accept;
  logic                  access_en;
  logic                  acc_wr;
  logic                  acc_sign;
  logic [1:0]            acc_type;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [DATA_WIDTH-1:0] rword;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata_al;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  misalign;
  logic                  bad;
  logic                  mem_we;
  logic                  unused_addr_hi;

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  assign req_ready_o    = (state_q == IDLE);
  assign accept         = req_valid_i & req_ready_o;
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign unused_addr_hi = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

  // With no wait states the access happens on the accept edge, so use the live request
  always_comb begin
    if (NO_WAIT) begin
      acc_wr    = req_write_i;
      acc_sign  = req_sign_i;
      acc_type  = req_type_i;
      acc_addr  = req_addr_i[ADDR_WIDTH-1:0];
      acc_wdata = req_wdata_i;
      access_en = accept;
    end else begin
      acc_wr    = wr_q;
      acc_sign  = sign_q;
      acc_type  = type_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      access_en = (state_q == WAIT) && (cnt_q == WAIT_CNT_W'(1));
    end
  end

  assign word_idx = acc_addr[ADDR_WIDTH-1:2];
  assign rword    = storage[word_idx];

  dmem_lane_align u_align (
    .addr_lo_i  (acc_addr[1:0]),
    .type_i     (acc_type),
    .sign_i     (acc_sign),
    .wdata_i    (acc_wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_al),
    .rdata_o    (load_data),
    .misalign_o (misalign)
  );

`ifdef DMEM_MISALIGN_ERR_EN
  assign bad = misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign bad             = 1'b0;
`endif

  // A store in flight when reset asserts must never reach storage
  assign mem_we = rst & access_en & acc_wr & ~bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_d    = wr_q;
    sign_d  = sign_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept) begin
      wr_d    = req_write_i;
      sign_d  = req_sign_i;
      type_d  = req_type_i;
      addr_d  = req_addr_i[ADDR_WIDTH-1:0];
      wdata_d = req_wdata_i;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (access_en) begin
      rdata_d = (acc_wr | bad) ? '0 : load_data;
      err_d   = bad;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    sign_q  <= sign_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && be[b]) storage[word_idx][8*b +: 8] <= wdata_al[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance a has two wait states, instance b has none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_write, a_req_sign;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_type;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_sign;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [1:0]  b_req_type;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_type_i(a_req_type),
    .req_sign_i(a_req_sign), .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_type_i(b_req_type),
    .req_sign_i(b_req_sign), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  task automatic drive(input bit b, input bit v, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] typ, input bit sgn);
    if (b) begin
      b_req_valid = v; b_req_write = wr; b_req_addr = addr;
      b_req_wdata = wd; b_req_type = typ; b_req_sign = sgn;
    end else begin
      a_req_valid = v; a_req_write = wr; a_req_addr = addr;
      a_req_wdata = wd; a_req_type = typ; a_req_sign = sgn;
    end
  endtask

  task automatic set_rsp_ready(input bit b, input bit r);
    if (b) b_rsp_ready = r;
    else   a_rsp_ready = r;
  endtask

  function automatic logic rdy(input bit b);
    return b ? b_req_ready : a_req_ready;
  endfunction

  function automatic logic vld(input bit b);
    return b ? b_rsp_valid : a_rsp_valid;
  endfunction

  // One request; cyc counts cycles from the accept cycle (1) to the first rsp_valid cycle
  task automatic xact(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] typ, input bit sgn, input bit take,
                      output logic [31:0] rd, output logic er, output int cyc);
    int n;
    @(negedge clk);
    drive(b, 1'b1, wr, addr, wd, typ, sgn);
    n = 0;
    while (!rdy(b) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    drive(b, 1'b0, ~wr, 32'hFFFF_FFFF, 32'h5555_5555, 2'b11, ~sgn);
    cyc = 1;
    n   = 0;
    while (!vld(b) && n < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      n++;
    end
    rd = b ? b_rsp_rdata : a_rsp_rdata;
    er = b ? b_rsp_err : a_rsp_err;
    if (take) begin
      set_rsp_ready(b, 1'b1);
      @(posedge clk);
      #1;
      set_rsp_ready(b, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_rsp_err); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_req_ready); end
    checks++; if (b_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", b_rsp_valid); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int cyc;
    xact(0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL store_latency: got %0d want 3", cyc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL load_latency: got %0d want 3", cyc); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_word: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_word_err: got %b want 0", er); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er; int cyc;
    xact(0, 1, 32'h10, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    xact(0, 1, 32'h13, 32'hAAAA_AA80, 2'b00, 0, 1, rd, er, cyc);
    xact(0, 0, 32'h13, 32'h0, 2'b00, 1, 1, rd, er, cyc);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", rd); end
    xact(0, 0, 32'h13, 32'h0, 2'b00, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned: got %h want 00000080", rd); end
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL lw_after_sb: got %h want 80000000", rd); end
    xact(0, 1, 32'h14, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    xact(0, 1, 32'h16, 32'h1234_BEEF, 2'b01, 0, 1, rd, er, cyc);
    xact(0, 0, 32'h16, 32'h0, 2'b01, 1, 1, rd, er, cyc);
    checks++; if (rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_signed: got %h want ffffbeef", rd); end
    xact(0, 0, 32'h14, 32'h0, 2'b11, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'hBEEF_0000) begin errors++; $display("FAIL type11_word: got %h want beef0000", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int cyc;
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 0, rd, er, cyc);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL bp_first: got %h want 80000000", rd); end
    repeat (5) begin
      @(negedge clk);
      drive(0, 1, 1, 32'h10, 32'h0, 2'b10, 0);
      @(posedge clk);
      #1;
      checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", a_rsp_valid); end
      checks++; if (a_rsp_rdata !== 32'h8000_0000) begin errors++; $display("FAIL bp_rdata: got %h want 80000000", a_rsp_rdata); end
      checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", a_req_ready); end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", a_rsp_valid); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second: got %b want 0", a_rsp_valid); end
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL bp_store_blocked: got %h want 80000000", rd); end
  endtask

  task automatic test_back_to_back();
    int accepts, resps;
    accepts = 0;
    resps   = 0;
    @(negedge clk);
    a_rsp_ready = 1'b1;
    drive(0, 1, 0, 32'h10, 32'h0, 2'b10, 0);
    for (int i = 0; i < 12; i++) begin
      if (a_req_ready) accepts++;
      if (a_rsp_valid) begin
        resps++;
        checks++; if (a_rsp_rdata !== 32'h8000_0000) begin errors++; $display("FAIL b2b_rdata: got %h want 80000000", a_rsp_rdata); end
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    a_rsp_ready = 1'b0;
    checks++; if (accepts != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", accepts); end
    checks++; if (resps != 3) begin errors++; $display("FAIL b2b_resps: got %0d want 3", resps); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", a_rsp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int cyc;
    xact(0, 1, 32'h20, 32'h1111_1111, 2'b10, 0, 1, rd, er, cyc);
    xact(0, 0, 32'h20, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rmw_setup: got %h want 11111111", rd); end
    @(negedge clk);
    drive(0, 1, 1, 32'h20, 32'h1234_5678, 2'b10, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL rmw_in_wait: got ready %b want 0", a_req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid: got %b want 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rmw_rdata: got %h want 0", a_rsp_rdata); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b want 1", a_req_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_no_resp: got %b want 0", a_rsp_valid); end
    xact(0, 0, 32'h20, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL rmw_store_dropped: got %h want 11111111", rd); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL rmw_latency: got %0d want 3", cyc); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int cyc;
    logic [31:0] exp_lh, exp_lw;
    logic        exp_err;
`ifdef DMEM_MISALIGN_ERR_EN
    exp_lh  = 32'h0;
    exp_err = 1'b1;
    exp_lw  = 32'h8001_A5A5;
`else
    exp_lh  = 32'h0000_A5A5;
    exp_err = 1'b0;
    exp_lw  = 32'h0102_0304;
`endif
    xact(0, 1, 32'h10, 32'h8001_A5A5, 2'b10, 0, 1, rd, er, cyc);
    xact(0, 0, 32'h11, 32'h0, 2'b01, 0, 1, rd, er, cyc);
    checks++; if (rd !== exp_lh) begin errors++; $display("FAIL mis_lh_rdata: got %h want %h", rd, exp_lh); end
    checks++; if (er !== exp_err) begin errors++; $display("FAIL mis_lh_err: got %b want %b", er, exp_err); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL mis_latency: got %0d want 3", cyc); end
    xact(0, 1, 32'h12, 32'h0102_0304, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (er !== exp_err) begin errors++; $display("FAIL mis_sw_err: got %b want %b", er, exp_err); end
    xact(0, 0, 32'h10, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== exp_lw) begin errors++; $display("FAIL mis_lw: got %h want %h", rd, exp_lw); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_aligned_err: got %b want 0", er); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic er; int cyc;
    xact(1, 1, 32'h0001_0004, 32'h5A5A_C3C3, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL alias_store_latency: got %0d want 1", cyc); end
    xact(1, 0, 32'h0000_0004, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h5A5A_C3C3) begin errors++; $display("FAIL alias_load: got %h want 5a5ac3c3", rd); end
    checks++; if (cyc != 1) begin errors++; $display("FAIL alias_load_latency: got %0d want 1", cyc); end
    xact(1, 1, 32'hFFFF_0005, 32'h0000_0077, 2'b00, 0, 1, rd, er, cyc);
    xact(1, 0, 32'h0000_0004, 32'h0, 2'b10, 0, 1, rd, er, cyc);
    checks++; if (rd !== 32'h5A5A_77C3) begin errors++; $display("FAIL alias_byte: got %h want 5a5a77c3", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_misalign();
    test_alias();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
